// File: rtl/and4_chk_if.sv
// Handshake bundle between the 16-vector stimulus source and and4_resp_checker.
// The master side drives vectors and the observed gate output; the slave side reports the verdict.
interface and4_chk_if #(
    parameter int unsigned ERR_W = 8
);
    logic             start;
    logic             vec_valid;
    logic [3:0]       vec;
    logic             y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [15:0]      cov_map;
    logic [3:0]       first_err_vec;
    logic             first_err_valid;
    logic             timeout;

    modport master (
        output start, vec_valid, vec, y,
        input  busy, done, pass, err_count, cov_map, first_err_vec, first_err_valid, timeout
    );

    modport slave (
        input  start, vec_valid, vec, y,
        output busy, done, pass, err_count, cov_map, first_err_vec, first_err_valid, timeout
    );
endinterface

// File: rtl/and4_resp_checker.sv
// Response checker for a 4-input AND gate driven by an exhaustive 16-vector sweep.
// Optional idle watchdog is enabled by defining AND4_CHK_TIMEOUT_EN.
module and4_resp_checker #(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned ERR_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    and4_chk_if.slave  chk
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_VEC = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_SAMPLE   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    function automatic logic and4_expect(input logic [3:0] v);
        return &v;
    endfunction

    state_t           state_r, state_s;
    logic [7:0]       cnt_r, cnt_s;
    logic [3:0]       vec_q_r, vec_q_s;
    logic             y_q_r, y_q_s;
    logic [ERR_W-1:0] err_r, err_s;
    logic [15:0]      cov_r, cov_s;
    logic [3:0]       fev_r, fev_s;
    logic             fevv_r, fevv_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             pass_r, pass_s;

`ifdef AND4_CHK_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    logic [IDLE_W-1:0] idle_r, idle_s;
    logic              tmo_r, tmo_s;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^(32'(TIMEOUT));
`endif

    // Next-state and next-output logic; y is captured on the last settle cycle.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        vec_q_s = vec_q_r;
        y_q_s   = y_q_r;
        err_s   = err_r;
        cov_s   = cov_r;
        fev_s   = fev_r;
        fevv_s  = fevv_r;
`ifdef AND4_CHK_TIMEOUT_EN
        idle_s  = idle_r;
        tmo_s   = tmo_r;
`endif
        if (chk.start) begin
            state_s = ST_WAIT_VEC;
            err_s   = {ERR_W{1'b0}};
            cov_s   = 16'h0000;
            fev_s   = 4'h0;
            fevv_s  = 1'b0;
`ifdef AND4_CHK_TIMEOUT_EN
            idle_s  = {IDLE_W{1'b0}};
            tmo_s   = 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_WAIT_VEC: begin
                    if (chk.vec_valid) begin
                        vec_q_s = chk.vec;
                        cnt_s   = SETTLE_LOAD;
                        state_s = ST_SETTLE;
                    end else begin
`ifdef AND4_CHK_TIMEOUT_EN
                        if (idle_r == IDLE_LAST) begin
                            tmo_s   = 1'b1;
                            state_s = ST_DONE;
                        end else begin
                            idle_s  = idle_r + IDLE_W'(1);
                        end
`else
                        state_s = ST_WAIT_VEC;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (chk.vec_valid) begin
                        vec_q_s = chk.vec;
                        cnt_s   = SETTLE_LOAD;
                    end else if (cnt_r == 8'd0) begin
                        y_q_s   = chk.y;
                        state_s = ST_SAMPLE;
                    end else begin
                        cnt_s   = cnt_r - 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (y_q_r != and4_expect(vec_q_r)) begin
                        if (err_r != ERR_MAX) begin
                            err_s = err_r + ERR_W'(1);
                        end else begin
                            err_s = err_r;
                        end
                        if (!fevv_r) begin
                            fev_s  = vec_q_r;
                            fevv_s = 1'b1;
                        end else begin
                            fevv_s = fevv_r;
                        end
                    end else begin
                        err_s = err_r;
                    end
                    cov_s = cov_r | (16'h0001 << vec_q_r);
`ifdef AND4_CHK_TIMEOUT_EN
                    idle_s = {IDLE_W{1'b0}};
`endif
                    if (cov_s == 16'hFFFF) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_WAIT_VEC;
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        busy_s = (state_s == ST_WAIT_VEC) || (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
        done_s = (state_s == ST_DONE);
`ifdef AND4_CHK_TIMEOUT_EN
        pass_s = done_s && (err_s == {ERR_W{1'b0}}) && !tmo_s;
`else
        pass_s = done_s && (err_s == {ERR_W{1'b0}});
`endif
    end

    // State, datapath and result registers; outputs come straight from these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            vec_q_r <= 4'h0;
            y_q_r   <= 1'b0;
            err_r   <= {ERR_W{1'b0}};
            cov_r   <= 16'h0000;
            fev_r   <= 4'h0;
            fevv_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            vec_q_r <= vec_q_s;
            y_q_r   <= y_q_s;
            err_r   <= err_s;
            cov_r   <= cov_s;
            fev_r   <= fev_s;
            fevv_r  <= fevv_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
        end
    end

`ifdef AND4_CHK_TIMEOUT_EN
    // Watchdog idle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_r <= {IDLE_W{1'b0}};
            tmo_r  <= 1'b0;
        end else begin
            idle_r <= idle_s;
            tmo_r  <= tmo_s;
        end
    end

    assign chk.timeout = tmo_r;
`else
    assign chk.timeout = 1'b0;
`endif

    assign chk.busy            = busy_r;
    assign chk.done            = done_r;
    assign chk.pass            = pass_r;
    assign chk.err_count       = err_r;
    assign chk.cov_map         = cov_r;
    assign chk.first_err_vec   = fev_r;
    assign chk.first_err_valid = fevv_r;
endmodule

// File: tb/tb_and4_resp_checker.sv
// Randomized self-checking bench for and4_resp_checker: two instances (ERR_W 8 and 2) share stimulus
// and are compared every cycle against a timestamp-based reference model.
module tb_and4_resp_checker;
    localparam int unsigned SETTLE  = 2;
    localparam int unsigned TIMEOUT = 64;
`ifdef AND4_CHK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic [3:0] vec = 4'h0;
    logic       y = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    and4_chk_if #(.ERR_W(8)) bus_a ();
    and4_chk_if #(.ERR_W(2)) bus_b ();

    assign bus_a.start = start;
    assign bus_a.vec_valid = vec_valid;
    assign bus_a.vec = vec;
    assign bus_a.y = y;
    assign bus_b.start = start;
    assign bus_b.vec_valid = vec_valid;
    assign bus_b.vec = vec;
    assign bus_b.y = y;

    and4_resp_checker #(.SETTLE(SETTLE), .ERR_W(8), .TIMEOUT(TIMEOUT)) dut_a (
        .clk(clk), .rst_n(rst_n), .chk(bus_a.slave));
    and4_resp_checker #(.SETTLE(SETTLE), .ERR_W(2), .TIMEOUT(TIMEOUT)) dut_b (
        .clk(clk), .rst_n(rst_n), .chk(bus_b.slave));

    always #5 clk = ~clk;

    // Reference model: run status plus one pending vector stamped with its strobe cycle.
    int         cyc = 0;
    bit         m_active, m_done, m_tmo, m_fevv, m_pend, m_ycap;
    int         m_raw, m_pend_t, m_wait_since;
    logic [15:0] m_cov;
    logic [3:0]  m_fev, m_pend_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_active = 1'b0; m_done = 1'b0; m_tmo = 1'b0; m_fevv = 1'b0; m_pend = 1'b0;
        m_ycap = 1'b0; m_raw = 0; m_pend_t = 0; m_wait_since = 0;
        m_cov = 16'h0000; m_fev = 4'h0; m_pend_vec = 4'h0;
    endtask

    task automatic m_step(input logic st, input logic vv, input logic [3:0] v, input logic yy);
        int t;
        t = cyc;
        if (st) begin
            m_reset();
            m_active = 1'b1;
            m_wait_since = t + 1;
        end else if (m_active) begin
            if (m_pend && t == m_pend_t + int'(SETTLE) + 1) begin
                if (m_ycap != (m_pend_vec == 4'hF)) begin
                    m_raw++;
                    if (!m_fevv) begin
                        m_fevv = 1'b1;
                        m_fev = m_pend_vec;
                    end
                end
                m_cov[m_pend_vec] = 1'b1;
                m_pend = 1'b0;
                if (m_cov == 16'hFFFF) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_wait_since = t + 1;
                end
            end else if (vv) begin
                m_pend = 1'b1;
                m_pend_vec = v;
                m_pend_t = t;
            end else if (m_pend && t == m_pend_t + int'(SETTLE)) begin
                m_ycap = yy;
            end else if (!m_pend && TMO_EN && (t - m_wait_since) == int'(TIMEOUT) - 1) begin
                m_tmo = 1'b1;
                m_active = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic cmp_dut(input string tag, input logic busy, input logic done, input logic pass,
                           input logic [7:0] err, input logic [15:0] cov, input logic [3:0] fev,
                           input logic fevv, input logic tmo, input int errmax);
        int exp_err;
        exp_err = (m_raw > errmax) ? errmax : m_raw;
        check({tag, ".busy"}, 32'(busy), 32'(m_active));
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".pass"}, 32'(pass), 32'(m_done && m_raw == 0 && !m_tmo));
        check({tag, ".err_count"}, 32'(err), 32'(exp_err));
        check({tag, ".cov_map"}, 32'(cov), 32'(m_cov));
        check({tag, ".first_err_vec"}, 32'(fev), 32'(m_fev));
        check({tag, ".first_err_valid"}, 32'(fevv), 32'(m_fevv));
        check({tag, ".timeout"}, 32'(tmo), 32'(m_tmo));
    endtask

    // Compare process: on each falling edge check outputs, then advance the model by the coming edge.
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) m_reset();
            cmp_dut("a", bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.cov_map,
                    bus_a.first_err_vec, bus_a.first_err_valid, bus_a.timeout, 255);
            cmp_dut("b", bus_b.busy, bus_b.done, bus_b.pass, 8'(bus_b.err_count), bus_b.cov_map,
                    bus_b.first_err_vec, bus_b.first_err_valid, bus_b.timeout, 3);
            if (!rst_n) m_reset();
            else m_step(start, vec_valid, vec, y);
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic apply_vec(input logic [3:0] v, input logic yv, input int gap);
        vec = v;
        y = yv;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        for (int i = 1; i < gap; i++) tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !bus_a.done; i++) tick();
        check({name, ".done_seen"}, 32'(bus_a.done), 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(bus_a.busy), 32'd0);
        check("reset.done", 32'(bus_a.done), 32'd0);
        check("reset.pass", 32'(bus_a.pass), 32'd0);
        check("reset.err", 32'(bus_a.err_count), 32'd0);
        check("reset.cov", 32'(bus_a.cov_map), 32'd0);
        check("reset.fevv", 32'(bus_a.first_err_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // Ideal sweep
        do_start();
        for (int v = 0; v < 16; v++) apply_vec(4'(v), (v == 15), 10);
        wait_done("ideal", 40);
        check("ideal.pass", 32'(bus_a.pass), 32'd1);
        check("ideal.err", 32'(bus_a.err_count), 32'd0);
        check("ideal.cov", 32'(bus_a.cov_map), 32'h0000FFFF);
        check("ideal.fevv", 32'(bus_a.first_err_valid), 32'd0);
        repeat (5) tick();
        check("ideal.done_held", 32'(bus_a.done), 32'd1);

        // Stuck-at-0
        do_start();
        check("restart.cov_cleared", 32'(bus_a.cov_map), 32'd0);
        for (int v = 0; v < 16; v++) apply_vec(4'(v), 1'b0, 10);
        wait_done("sa0", 40);
        check("sa0.err", 32'(bus_a.err_count), 32'd1);
        check("sa0.fev", 32'(bus_a.first_err_vec), 32'hF);
        check("sa0.pass", 32'(bus_a.pass), 32'd0);

        // Stuck-at-1
        do_start();
        for (int v = 0; v < 16; v++) apply_vec(4'(v), 1'b1, 10);
        wait_done("sa1", 40);
        check("sa1.err", 32'(bus_a.err_count), 32'd15);
        check("sa1.err_sat_b", 32'(bus_b.err_count), 32'd3);
        check("sa1.fev", 32'(bus_a.first_err_vec), 32'h0);
        check("sa1.pass", 32'(bus_a.pass), 32'd0);

        // Saturation and repeats
        do_start();
        for (int i = 0; i < 5; i++) apply_vec(4'h0, 1'b1, 6);
        check("rep.cov_once", 32'(bus_a.cov_map), 32'h1);
        for (int v = 1; v < 16; v++) apply_vec(4'(v), (v == 15), 6);
        wait_done("rep", 40);
        check("rep.err_b_sat", 32'(bus_b.err_count), 32'd3);
        check("rep.err_a", 32'(bus_a.err_count), 32'd5);
        check("rep.cov", 32'(bus_b.cov_map), 32'h0000FFFF);
        check("rep.done_b", 32'(bus_b.done), 32'd1);

        // Supersede, then asynchronous reset mid-run
        do_start();
        apply_vec(4'h3, 1'b0, 1);
        apply_vec(4'h5, 1'b0, 10);
        check("sup.cov", 32'(bus_a.cov_map), 32'h0020);
        apply_vec(4'h6, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        check("arst.busy", 32'(bus_a.busy), 32'd0);
        check("arst.cov", 32'(bus_a.cov_map), 32'd0);
        check("arst.err", 32'(bus_b.err_count), 32'd0);
        check("arst.done", 32'(bus_a.done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef AND4_CHK_TIMEOUT_EN
        do_start();
        for (int v = 0; v < 8; v++) apply_vec(4'(v), 1'b0, 6);
        repeat (70) tick();
        check("tmo.timeout", 32'(bus_a.timeout), 32'd1);
        check("tmo.done", 32'(bus_a.done), 32'd1);
        check("tmo.pass", 32'(bus_a.pass), 32'd0);
        check("tmo.cov", 32'(bus_a.cov_map), 32'h00FF);
`endif

        // Randomized runs with supersedes, ignored strobes, wrong responses and restarts
        for (int run = 0; run < 6; run++) begin
            do_start();
            for (int k = 0; k < 300; k++) begin
                logic [3:0] rv;
                logic       good;
                if (bus_a.done) break;
                if ($urandom_range(59) == 0) begin
                    do_start();
                end else begin
                    rv = 4'($urandom_range(15));
                    good = (rv == 4'hF);
                    apply_vec(rv, ($urandom_range(3) == 0) ? ~good : good, int'($urandom_range(6, 1)));
                end
            end
            repeat (4) tick();
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout: got no finish, expected finish within bound");
        $fatal(1, "simulation time bound expired");
    end
endmodule

// File: doc/and4_resp_checker.md
# and4_resp_checker

Synthesizable response checker for the 4-input AND gate and the receiving end of the exhaustive 16-vector stimulus sequence. The stimulus source reports each applied vector with a strobe. This block waits a fixed settle time, samples the gate output and compares it with the expected AND of the vector. It accumulates errors and coverage and reports a single pass/fail verdict once all 16 input combinations have been checked. It sits beside the `and4` instance in the self-checking simulation and FPGA bring-up harness.

## Interface
- `SETTLE` — default 2: cycles from vector strobe to output sample. Legal range 1..255.
- `ERR_W` — default 8: width of the error counter.
- `TIMEOUT` — default 64: idle watchdog limit in cycles. Used only with the config macro.

Ports (one clock; reset is asynchronous, active-low):
- `clk` — in, 1: sole clock, rising edge.
- `rst_n` — in, 1: asynchronous active-low reset.
- `start` — in, 1: one-cycle pulse that begins or restarts a check run.
- `vec_valid` — in, 1: a new vector is applied on `vec` this cycle.
- `vec` — in, 4: applied inputs `{a,b,c,d}`, with `a` as MSB.
- `y` — in, 1: DUT output under check.
- `busy` — out, 1: a run is in progress.
- `done` — out, 1: the run has finished; held until the next start or reset.
- `pass` — out, 1: valid when `done`; 1 iff `err_count==0` and no timeout.
- `err_count` — out, ERR_W: number of mismatches, saturating.
- `cov_map` — out, 16: bit i set once vector i has been checked.
- `first_err_vec` — out, 4: vector of the first mismatch.
- `first_err_valid` — out, 1: `first_err_vec` holds a captured value.
- `timeout` — out, 1: the watchdog fired.

## Operation
- FSM states are IDLE, WAIT_VEC, SETTLE, SAMPLE and DONE.
- IDLE:
  - `start` moves to WAIT_VEC.
  - On the same edge, `err_count`, `cov_map`, `first_err_*` and `timeout` are cleared.
- WAIT_VEC: `vec_valid` latches `vec` into `vec_q`, loads the settle counter with SETTLE-1 and moves to SETTLE.
- SETTLE:
  - The counter decrements each cycle; at 0 the FSM moves to SAMPLE.
  - A new `vec_valid` here re-latches `vec`, reloads the counter and stays in SETTLE. The superseded vector is discarded, not checked and not covered.
- SAMPLE:
  - Expected value is `&vec_q`.
  - On mismatch, `err_count` increments and saturates at 2^ERR_W-1. On the first mismatch of the run, `first_err_vec<=vec_q` and `first_err_valid<=1`.
  - `cov_map[vec_q]` is always set.
  - If the resulting `cov_map` is 16'hFFFF, move to DONE; otherwise return to WAIT_VEC.
- Repeated vectors are re-checked and their errors counted; coverage is unchanged.
- A `vec_valid` that arrives in the SAMPLE cycle itself is ignored.
- DONE:
  - `done` is 1 and `busy` is 0.
  - `pass = (err_count==0) && !timeout`.
  - `start` restarts the run exactly as from IDLE.
- `start` while busy aborts the current run and restarts with all state cleared, going to WAIT_VEC.
- `busy` is 1 in WAIT_VEC, SETTLE and SAMPLE.

## Timing
- Reset values:
  - state IDLE
  - `busy`, `done`, `pass`, `timeout` and `first_err_valid` all 0
  - `err_count` 0, `cov_map` 0, `first_err_vec` 0
- Latency:
  - `vec_valid` at cycle N causes `y` to be sampled at cycle N+SETTLE.
  - `err_count` and `cov_map` update at N+SETTLE+1.
  - `done` and `pass` become visible at N+SETTLE+1 on the final vector.
- Minimum vector spacing for every vector to be checked is SETTLE+2 cycles.
- Reset assertion mid-run clears everything immediately, asynchronously. Release is synchronous to `clk`.
- All outputs are registered.

## Configuration
- `AND4_CHK_TIMEOUT_EN` defined:
  - An idle counter runs in WAIT_VEC and clears on `vec_valid`.
  - On reaching TIMEOUT cycles, `timeout<=1` and the FSM moves to DONE with `pass=0`. Coverage and errors are retained.
- `AND4_CHK_TIMEOUT_EN` undefined: no watchdog logic; `timeout` is tied to 0 and WAIT_VEC waits indefinitely.

## Test plan
- **Ideal sweep.** Correct `y` for vectors 0..15, spaced 10 cycles, SETTLE=2 -> `done=1`, `pass=1`, `err_count=0`, `cov_map=16'hFFFF`, `first_err_valid=0`.
- **Stuck-at-0.** `y` stuck at 0 over the full sweep -> `err_count=1`, `first_err_vec=4'hF`, `pass=0`.
- **Stuck-at-1.** `y` stuck at 1 over an ascending sweep -> `err_count=15`, `first_err_vec=4'h0`, `pass=0`.
- **Saturation and repeats.** ERR_W=2, vector 0 with `y=1` applied 5 times, then the rest correct -> `err_count=3` (saturated), `cov_map=16'hFFFF`, `done=1`.
- **Supersede and reset.**
  - Strobe vector 3, then strobe vector 5 one cycle later -> only bit 5 is set in `cov_map`.
  - Pulse `rst_n` low mid-run -> all outputs return to reset values within the same cycle.
- **Timeout (macro defined).** TIMEOUT=64, 8 vectors applied, then silence -> `timeout=1`, `done=1`, `pass=0`, `cov_map=16'h00FF`, 64 cycles after entering WAIT_VEC.
